// File: rtl/note_scheduler.sv
// Frame-rate beat scheduler: scrolls four beat slots and fetches a new note line per wrap.
// Define NOTE_SCHED_LOOP_EN to loop the song; otherwise playback stops at the last ROM line.
module note_scheduler #(
  parameter int PIXELSPEED = 5,
  parameter int NOTELENGTH = 150,
  parameter int HSPAN      = 640,
  parameter int ROM_AW     = 8,
  parameter int ROM_DEPTH  = 256
) (
  input  logic              vgaclk,
  input  logic              rst_n,
  input  logic              frame_tick,
  input  logic              pause,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [9:0]        beat_pos1,
  output logic [9:0]        beat_pos2,
  output logic [9:0]        beat_pos3,
  output logic [9:0]        beat_pos4,
  output logic [3:0]        beat_notes1,
  output logic [3:0]        beat_notes2,
  output logic [3:0]        beat_notes3,
  output logic [3:0]        beat_notes4,
  output logic              busy,
  output logic              overrun,
  output logic              song_end
);

  localparam logic [9:0]        WRAP_AT   = 10'(HSPAN - 1 + NOTELENGTH);
  localparam logic [9:0]        STEP      = 10'(PIXELSPEED);
  localparam logic [ROM_AW-1:0] LAST_ADDR = ROM_AW'(ROM_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD} state_t;

  state_t     state, state_next;
  logic [9:0] pos [4];
  logic [3:0] notes [4];
  logic [3:0] pending;
  logic [3:0] wrap_mask;
  logic [1:0] sel;
  logic       start;

  assign start = (state == IDLE) && frame_tick && !pause;
  assign busy  = (state != IDLE);

  always_comb begin
    wrap_mask = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      wrap_mask[i] = (pos[i] >= WRAP_AT);
    end
  end

  // Descending scan so the lowest-numbered pending slot wins.
  always_comb begin
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) sel = 2'(i);
    end
  end

  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && (wrap_mask != 4'b0000)) state_next = FETCH;
      FETCH:   state_next = LOAD;
      LOAD:    state_next = ((pending & ~(4'b0001 << sel)) != 4'b0000) ? FETCH : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        pos[i]   <= 10'(i * (HSPAN / 4));
        notes[i] <= 4'b0000;
      end
      pending  <= 4'b0000;
      rom_addr <= '0;
      overrun  <= 1'b0;
      song_end <= 1'b0;
    end else begin
      if (frame_tick && busy) overrun <= 1'b1;

      if (start) begin
        for (int i = 0; i < 4; i++) begin
          pos[i] <= wrap_mask[i] ? 10'd0 : pos[i] + STEP;
        end
        pending <= wrap_mask;
      end

      // ROM sampled rom_addr on the FETCH->LOAD edge, so rom_data is valid now.
      if (state == LOAD) begin
        pending[sel] <= 1'b0;
`ifdef NOTE_SCHED_LOOP_EN
        notes[sel] <= rom_data;
`else
        notes[sel] <= song_end ? 4'b0000 : rom_data;
`endif
        if (rom_addr == LAST_ADDR) begin
          song_end <= 1'b1;
`ifdef NOTE_SCHED_LOOP_EN
          rom_addr <= '0;
`endif
        end else begin
          rom_addr <= rom_addr + ROM_AW'(1);
        end
      end
    end
  end

  assign beat_pos1   = pos[0];
  assign beat_pos2   = pos[1];
  assign beat_pos3   = pos[2];
  assign beat_pos4   = pos[3];
  assign beat_notes1 = notes[0];
  assign beat_notes2 = notes[1];
  assign beat_notes3 = notes[2];
  assign beat_notes4 = notes[3];

endmodule
